// File: rtl/demux_fifo_1a2_if.sv
// Handshake bundle for demux_fifo_1a2: one shared write port steered to two FWFT lanes,
// with per-lane pop/head/status, plus the pause and sticky underflow indicators.
interface demux_fifo_1a2_if #(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned DEPTH      = 4
);
  logic [DATA_WIDTH:0]       data_in;
  logic                      valid_in;
  logic                      ready_out;
  logic                      pop_0;
  logic                      pop_1;
  logic [DATA_WIDTH-1:0]     data_out_0;
  logic [DATA_WIDTH-1:0]     data_out_1;
  logic                      valid_out_0;
  logic                      valid_out_1;
  logic [$clog2(DEPTH):0]    count_0;
  logic [$clog2(DEPTH):0]    count_1;
  logic                      full_0;
  logic                      full_1;
  logic                      empty_0;
  logic                      empty_1;
  logic                      pause;
  logic                      err_underflow;

  modport master (
    output data_in, valid_in, pop_0, pop_1,
    input  ready_out, data_out_0, data_out_1, valid_out_0, valid_out_1,
    input  count_0, count_1, full_0, full_1, empty_0, empty_1, pause, err_underflow
  );

  modport slave (
    input  data_in, valid_in, pop_0, pop_1,
    output ready_out, data_out_0, data_out_1, valid_out_0, valid_out_1,
    output count_0, count_1, full_0, full_1, empty_0, empty_1, pause, err_underflow
  );
endinterface

// File: rtl/demux_fifo_1a2.sv
// Two-lane demultiplexing FIFO: the top data_in bit picks the lane, each lane is a
// first-word-fall-through queue with registered storage, pause hint and sticky underflow flag.
module demux_fifo_1a2 #(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AF_THRESH  = 3
) (
  input logic             clk,
  input logic             reset,
  demux_fifo_1a2_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned NL = 2;

  logic [PW-1:0]         wptr_q  [NL];
  logic [PW-1:0]         wptr_d  [NL];
  logic [PW-1:0]         rptr_q  [NL];
  logic [PW-1:0]         rptr_d  [NL];
  logic [CW-1:0]         count_q [NL];
  logic [CW-1:0]         count_d [NL];
  logic [DATA_WIDTH-1:0] head    [NL];

  logic [NL-1:0]         pop;
  logic [NL-1:0]         full;
  logic [NL-1:0]         empty;
  logic [NL-1:0]         wr_en;
  logic [NL-1:0]         rd_en;
  logic [NL-1:0]         underflow;
  logic                  lane_sel;
  logic                  ready;
  logic [DATA_WIDTH-1:0] payload;
  logic                  pause_q;
  logic                  pause_d;
  logic                  err_q;
  logic                  err_d;

  assign pop      = {bus.pop_1, bus.pop_0};
  assign lane_sel = bus.data_in[DATA_WIDTH];
  assign payload  = bus.data_in[DATA_WIDTH-1:0];

  always_comb begin
    full  = '0;
    empty = '0;
    for (int l = 0; l < NL; l++) begin
      full[l]  = (count_q[l] == CW'(DEPTH));
      empty[l] = (count_q[l] == '0);
    end
  end

  // Backpressure looks only at current occupancy; a same-cycle pop never frees a full lane.
  assign ready = !full[lane_sel];

  always_comb begin
    wr_en     = '0;
    rd_en     = '0;
    underflow = '0;
    for (int l = 0; l < NL; l++) begin
      wr_en[l]     = !reset && bus.valid_in && ready && (int'(lane_sel) == l);
      rd_en[l]     = !reset && pop[l] && !empty[l];
      underflow[l] = pop[l] && empty[l];
      wptr_d[l]    = wptr_q[l] + PW'(wr_en[l]);
      rptr_d[l]    = rptr_q[l] + PW'(rd_en[l]);
      count_d[l]   = count_q[l] + CW'(wr_en[l]) - CW'(rd_en[l]);
    end
    pause_d = (32'(count_d[0]) >= AF_THRESH) || (32'(count_d[1]) >= AF_THRESH);
    err_d   = err_q || (|underflow);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l < NL; l++) begin
        wptr_q[l]  <= '0;
        rptr_q[l]  <= '0;
        count_q[l] <= '0;
      end
      pause_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      for (int l = 0; l < NL; l++) begin
        wptr_q[l]  <= wptr_d[l];
        rptr_q[l]  <= rptr_d[l];
        count_q[l] <= count_d[l];
      end
      pause_q <= pause_d;
      err_q   <= err_d;
    end
  end

  for (genvar g = 0; g < NL; g++) begin : g_lane
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_en[g]) begin
        mem_q[wptr_q[g]] <= payload;
      end
    end

    // Storage is never cleared, so the head is masked while the lane is empty.
    assign head[g] = empty[g] ? '0 : mem_q[rptr_q[g]];
  end

  assign bus.ready_out     = ready;
  assign bus.data_out_0    = head[0];
  assign bus.data_out_1    = head[1];
  assign bus.valid_out_0   = !empty[0];
  assign bus.valid_out_1   = !empty[1];
  assign bus.count_0       = count_q[0];
  assign bus.count_1       = count_q[1];
  assign bus.full_0        = full[0];
  assign bus.full_1        = full[1];
  assign bus.empty_0       = empty[0];
  assign bus.empty_1       = empty[1];
  assign bus.pause         = pause_q;
  assign bus.err_underflow = err_q;
endmodule

// File: tb/tb_demux_fifo_1a2.sv
// Directed bench for demux_fifo_1a2: a vector table of per-cycle stimulus and expected
// post-edge state, followed by a hand-written fill/drain ordering sequence on lane 1.
module tb_demux_fifo_1a2;
  localparam int DW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  demux_fifo_1a2_if #(.DATA_WIDTH(DW), .DEPTH(4)) bus ();

  demux_fifo_1a2 #(.DATA_WIDTH(DW), .DEPTH(4), .AF_THRESH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       rst;
    logic       vin;
    logic [5:0] din;
    logic       p0;
    logic       p1;
    logic       rdy;
    logic [2:0] c0;
    logic [2:0] c1;
    logic [4:0] d0;
    logic [4:0] d1;
    logic       pause;
    logic       err;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] model_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic vin, input logic [5:0] din, input logic p0,
                     input logic p1, input logic rdy, input logic [2:0] c0, input logic [2:0] c1,
                     input logic [4:0] d0, input logic [4:0] d1, input logic pause,
                     input logic err);
    vec_t v;
    v.rst = rst; v.vin = vin; v.din = din; v.p0 = p0; v.p1 = p1; v.rdy = rdy;
    v.c0 = c0; v.c1 = c1; v.d0 = d0; v.d1 = d1; v.pause = pause; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic vin, input logic [5:0] din, input logic p0,
                       input logic p1);
    reset        = rst;
    bus.valid_in = vin;
    bus.data_in  = din;
    bus.pop_0    = p0;
    bus.pop_1    = p1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [2:0] c0, input logic [2:0] c1,
                             input logic [4:0] d0, input logic [4:0] d1, input logic pause,
                             input logic err);
    chk({tag, " count_0"}, bus.count_0, c0);
    chk({tag, " count_1"}, bus.count_1, c1);
    chk({tag, " data_out_0"}, bus.data_out_0, d0);
    chk({tag, " data_out_1"}, bus.data_out_1, d1);
    chk({tag, " valid_out_0"}, bus.valid_out_0, c0 != 0);
    chk({tag, " valid_out_1"}, bus.valid_out_1, c1 != 0);
    chk({tag, " empty_0"}, bus.empty_0, c0 == 0);
    chk({tag, " empty_1"}, bus.empty_1, c1 == 0);
    chk({tag, " full_0"}, bus.full_0, c0 == 4);
    chk({tag, " full_1"}, bus.full_1, c1 == 4);
    chk({tag, " pause"}, bus.pause, pause);
    chk({tag, " err_underflow"}, bus.err_underflow, err);
  endtask

  initial begin
    // rst vin din    p0 p1 rdy c0 c1 d0     d1     pause err
    add(0, 1, 6'h25, 0, 0, 1,  0, 1, 5'h00, 5'h05, 0, 0);  // lane 1 first word
    add(0, 1, 6'h01, 0, 0, 1,  1, 1, 5'h01, 5'h05, 0, 0);
    add(0, 1, 6'h02, 0, 0, 1,  2, 1, 5'h01, 5'h05, 0, 0);
    add(0, 1, 6'h03, 0, 0, 1,  3, 1, 5'h01, 5'h05, 1, 0);  // count_0 hits 3
    add(0, 1, 6'h04, 0, 0, 1,  4, 1, 5'h01, 5'h05, 1, 0);  // lane 0 full
    add(0, 1, 6'h05, 0, 0, 0,  4, 1, 5'h01, 5'h05, 1, 0);  // refused, held
    add(0, 1, 6'h26, 0, 0, 1,  4, 2, 5'h01, 5'h05, 1, 0);  // lane 1 still accepts
    add(0, 1, 6'h1F, 1, 0, 0,  3, 2, 5'h02, 5'h05, 1, 0);  // pop on full, write refused
    add(0, 1, 6'h1F, 0, 0, 1,  4, 2, 5'h02, 5'h05, 1, 0);  // accepted next cycle
    add(0, 0, 6'h00, 1, 0, 0,  3, 2, 5'h03, 5'h05, 1, 0);
    add(0, 0, 6'h00, 1, 0, 1,  2, 2, 5'h04, 5'h05, 0, 0);
    add(0, 0, 6'h00, 1, 0, 1,  1, 2, 5'h1F, 5'h05, 0, 0);
    add(0, 1, 6'h2A, 0, 1, 1,  1, 2, 5'h1F, 5'h06, 0, 0);  // write+pop lane 1
    add(0, 0, 6'h00, 1, 1, 1,  0, 1, 5'h00, 5'h0A, 0, 0);  // dual pop
    add(0, 0, 6'h00, 0, 1, 1,  0, 0, 5'h00, 5'h00, 0, 0);
    add(0, 0, 6'h00, 1, 0, 1,  0, 0, 5'h00, 5'h00, 0, 1);  // underflow lane 0
    add(0, 0, 6'h00, 0, 0, 1,  0, 0, 5'h00, 5'h00, 0, 1);  // sticky
    add(0, 1, 6'h07, 0, 0, 1,  1, 0, 5'h07, 5'h00, 0, 1);
    add(0, 1, 6'h0A, 0, 0, 1,  2, 0, 5'h07, 5'h00, 0, 1);
    add(0, 1, 6'h0B, 0, 0, 1,  3, 0, 5'h07, 5'h00, 1, 1);
    add(0, 1, 6'h28, 0, 1, 1,  3, 1, 5'h07, 5'h08, 1, 1);  // empty pop + write lane 1
    add(1, 1, 6'h09, 1, 0, 1,  0, 0, 5'h00, 5'h00, 0, 0);  // reset mid-traffic
    add(0, 0, 6'h00, 0, 0, 1,  0, 0, 5'h00, 5'h00, 0, 0);

    drive(1, 0, 6'h00, 0, 0);
    repeat (2) step();
    drive(1, 1, 6'h01, 1, 1);
    #1;
    chk("reset ready_out", bus.ready_out, 1'b1);
    step();
    check_state("reset", 0, 0, 5'h00, 5'h00, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].vin, vecs[i].din, vecs[i].p0, vecs[i].p1);
      #1;
      chk($sformatf("v%0d ready_out", i), bus.ready_out, vecs[i].rdy);
      step();
      check_state($sformatf("v%0d", i), vecs[i].c0, vecs[i].c1, vecs[i].d0, vecs[i].d1,
                  vecs[i].pause, vecs[i].err);
    end

    // Fill lane 1, confirm per-lane backpressure, then drain and check FIFO order.
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, {1'b1, 5'(5'h11 + k)}, 0, 0);
      model_q.push_back(5'(5'h11 + k));
      step();
    end
    drive(0, 1, 6'h3F, 0, 0);
    #1;
    chk("lane1 full ready_out", bus.ready_out, 1'b0);
    drive(0, 1, 6'h1F, 0, 0);
    #1;
    chk("lane0 ready_out while lane1 full", bus.ready_out, 1'b1);
    drive(0, 0, 6'h00, 0, 0);
    #1;
    chk("lane1 full_1", bus.full_1, 1'b1);
    chk("lane1 count_1", bus.count_1, 3'd4);
    chk("lane1 pause", bus.pause, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain %0d data_out_1", k), bus.data_out_1, model_q[0]);
      drive(0, 0, 6'h00, 0, 1);
      step();
      void'(model_q.pop_front());
    end
    drive(0, 0, 6'h00, 0, 0);
    #1;
    chk("drained empty_1", bus.empty_1, 1'b1);
    chk("drained data_out_1", bus.data_out_1, 5'h00);
    chk("drained pause", bus.pause, 1'b0);
    chk("drained err_underflow", bus.err_underflow, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
